ps2_host_tx: RTL and testbench

PS2_HOST_TX -- requirements
Module: ps2_host_tx

---
 rtl/ps2_host_tx.sv | 198 +++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues a start bit,
// shifts a byte plus odd parity and stop bit out on device clock edges,
// then checks the device acknowledge and waits for the bus to go idle.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_error,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    START,
    BITS,
    ACK_WAIT,
    RELEASE_WAIT
  } state_t;

  state_t           state, state_nxt;
  logic [INH_W-1:0] inh_cnt, inh_cnt_nxt;
  logic [TMO_W-1:0] tmo_cnt, tmo_cnt_nxt;
  logic [3:0]       bit_idx, bit_idx_nxt;
  logic             clk_oe_q, clk_oe_nxt;
  logic             data_oe_q, data_oe_nxt;
  logic             done_q, done_nxt;
  logic             err_q, err_nxt;
  logic             load_byte;

  logic [7:0]       byte_q;
  logic             parity_q;

  logic             ps2_clk_p0, ps2_clk_p1, ps2_clk_p2;
  logic             ps2_data_p0, ps2_data_p1;
  logic             clk_fall;

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

  // Two-flop synchronizers plus one history flop for falling-edge detect;
  // reset to the idle (high) level so no false edge follows reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ps2_clk_p0  <= 1'b1;
      ps2_clk_p1  <= 1'b1;
      ps2_clk_p2  <= 1'b1;
      ps2_data_p0 <= 1'b1;
      ps2_data_p1 <= 1'b1;
    end else begin
      ps2_clk_p0  <= ps2_clk_in;
      ps2_clk_p1  <= ps2_clk_p0;
      ps2_clk_p2  <= ps2_clk_p1;
      ps2_data_p0 <= ps2_data_in;
      ps2_data_p1 <= ps2_data_p0;
    end
  end

  assign clk_fall = ps2_clk_p2 & ~ps2_clk_p1;

  // Byte and parity are plain data: captured on acceptance, never reset.
  always_ff @(posedge clk) begin
    if (load_byte) begin
      byte_q   <= tx_data;
      parity_q <= odd_parity(tx_data);
    end
  end

  // State, counters and registered line drivers / status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      inh_cnt   <= '0;
      tmo_cnt   <= '0;
      bit_idx   <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state     <= state_nxt;
      inh_cnt   <= inh_cnt_nxt;
      tmo_cnt   <= tmo_cnt_nxt;
      bit_idx   <= bit_idx_nxt;
      clk_oe_q  <= clk_oe_nxt;
      data_oe_q <= data_oe_nxt;
      done_q    <= done_nxt;
      err_q     <= err_nxt;
    end
  end

  // Next-state, counter and line-driver decisions for the frame sequence.
  always_comb begin
    state_nxt   = state;
    inh_cnt_nxt = inh_cnt;
    tmo_cnt_nxt = tmo_cnt;
    bit_idx_nxt = bit_idx;
    clk_oe_nxt  = clk_oe_q;
    data_oe_nxt = data_oe_q;
    done_nxt    = 1'b0;
    err_nxt     = 1'b0;
    load_byte   = 1'b0;
    case (state)
      IDLE: begin
        clk_oe_nxt  = 1'b0;
        data_oe_nxt = 1'b0;
        inh_cnt_nxt = '0;
        tmo_cnt_nxt = '0;
        bit_idx_nxt = '0;
        if (tx_valid) begin
          load_byte  = 1'b1;
          clk_oe_nxt = 1'b1;
          state_nxt  = INHIBIT;
        end
      end
      INHIBIT: begin
        if (inh_cnt == INH_LAST) begin
          inh_cnt_nxt = '0;
          data_oe_nxt = 1'b1;
          state_nxt   = START;
        end else begin
          inh_cnt_nxt = inh_cnt + INH_W'(1);
        end
      end
      START: begin
        // Releasing the clock hands bus timing to the device.
        clk_oe_nxt  = 1'b0;
        bit_idx_nxt = '0;
        tmo_cnt_nxt = '0;
        state_nxt   = BITS;
      end
      BITS, ACK_WAIT, RELEASE_WAIT: begin
        tmo_cnt_nxt = tmo_cnt + TMO_W'(1);
        if (tmo_cnt == TMO_LAST) begin
          // Timeout wins over any edge seen in the same cycle.
          clk_oe_nxt  = 1'b0;
          data_oe_nxt = 1'b0;
          err_nxt     = 1'b1;
          tmo_cnt_nxt = '0;
          state_nxt   = IDLE;
        end else if (state == BITS) begin
          if (clk_fall) begin
            bit_idx_nxt = bit_idx + 4'd1;
            if (bit_idx < 4'd8) begin
              data_oe_nxt = ~byte_q[bit_idx[2:0]];
            end else if (bit_idx == 4'd8) begin
              data_oe_nxt = ~parity_q;
            end else begin
              data_oe_nxt = 1'b0;
              state_nxt   = ACK_WAIT;
            end
          end
        end else if (state == ACK_WAIT) begin
          if (clk_fall) begin
            if (!ps2_data_p1) begin
              state_nxt = RELEASE_WAIT;
            end else begin
              err_nxt   = 1'b1;
              state_nxt = IDLE;
            end
          end
        end else begin
          if (ps2_clk_p1 && ps2_data_p1) begin
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        clk_oe_nxt  = 1'b0;
        data_oe_nxt = 1'b0;
        state_nxt   = IDLE;
      end
    endcase
  end

  assign tx_ready    = (state == IDLE);
  assign tx_done     = done_q;
  assign tx_error    = err_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-collector bus with a behavioural PS/2 device,
// table-driven frames, random frames against a frame model, and hand-written
// timeout / reset / busy sequences.
module tb_ps2_host_tx;

  localparam int INH      = 40;
  localparam int TMO      = 3000;
  localparam int HALF     = 20;
  localparam int WAIT_MAX = INH + 200;

  logic       clk;
  logic       rst;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       tx_done;
  logic       tx_error;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic       dev_clk_rel;
  logic       dev_data_rel;
  logic       ps2_clk_line;
  logic       ps2_data_line;

  assign ps2_clk_line  = dev_clk_rel & ~ps2_clk_oe;
  assign ps2_data_line = dev_data_rel & ~ps2_data_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .tx_done    (tx_done),
    .tx_error   (tx_error),
    .ps2_clk_in (ps2_clk_line),
    .ps2_data_in(ps2_data_line),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Bus monitor, sampled on the falling system clock edge.
  int   cyc = 0;
  int   done_cnt = 0;
  int   err_cnt = 0;
  int   inh_run = 0;
  int   last_inh = 0;
  int   rel_cyc = 0;
  int   err_cyc = 0;
  logic [1:0] oe_at_err = 2'b00;
  logic prev_clk_oe = 1'b0;
  logic both_seen = 1'b0;

  always @(negedge clk) begin
    cyc      <= cyc + 1;
    done_cnt <= done_cnt + int'(tx_done);
    err_cnt  <= err_cnt + int'(tx_error);
    if (tx_done && tx_error) both_seen <= 1'b1;
    if (ps2_clk_oe && !ps2_data_oe) begin
      inh_run <= inh_run + 1;
    end else begin
      if (ps2_clk_oe && ps2_data_oe && inh_run != 0) last_inh <= inh_run;
      inh_run <= 0;
    end
    prev_clk_oe <= ps2_clk_oe;
    if (prev_clk_oe && !ps2_clk_oe) rel_cyc <= cyc;
    if (tx_error) begin
      err_cyc   <= cyc;
      oe_at_err <= {ps2_clk_oe, ps2_data_oe};
    end
  end

  typedef struct {
    logic [7:0]  data;
    bit          ack;
    logic [10:0] frame;
    bit          done;
    bit          err;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Frame as it appears on the data line, in transmit order:
  // start 0, eight data bits LSB first, odd parity, stop 1.
  function automatic logic [10:0] model_frame(input logic [7:0] d);
    logic [10:0] f;
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = d[i];
    f[9]  = (ones % 2 == 0) ? 1'b1 : 1'b0;
    f[10] = 1'b1;
    return f;
  endfunction

  task automatic send(input logic [7:0] d);
    int t;
    t = 0;
    while (tx_ready !== 1'b1 && t < WAIT_MAX) begin
      @(negedge clk);
      t++;
    end
    tx_valid = 1'b1;
    tx_data  = d;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Device side: wait for request-to-send, then generate n_edges clock
  // pulses, sampling the data line just before each falling edge.
  task automatic device_frame(input bit ack, input int n_edges,
                              output logic [10:0] cap, output bit ok);
    int t;
    cap = '0;
    ok  = 1'b0;
    t   = 0;
    while (ps2_clk_line !== 1'b0 && t < WAIT_MAX) begin
      @(negedge clk);
      t++;
    end
    while (!(ps2_clk_line === 1'b1 && ps2_data_line === 1'b0) && t < WAIT_MAX) begin
      @(negedge clk);
      t++;
    end
    if (t >= WAIT_MAX) return;
    ok = 1'b1;
    for (int i = 0; i < n_edges; i++) begin
      repeat (HALF) @(negedge clk);
      cap[i] = ps2_data_line;
      if (i == 10 && ack) begin
        dev_data_rel = 1'b0;
        repeat (2) @(negedge clk);
      end
      dev_clk_rel = 1'b0;
      repeat (HALF) @(negedge clk);
      dev_clk_rel = 1'b1;
    end
    if (ack && n_edges == 11) begin
      repeat (HALF) @(negedge clk);
      dev_data_rel = 1'b1;
    end
  endtask

  task automatic wait_result(input int base_d, input int base_e);
    int t;
    t = 0;
    while ((done_cnt + err_cnt) == (base_d + base_e) && t < 200) begin
      @(negedge clk);
      t++;
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic run_frame(input string name, input logic [7:0] d, input bit ack,
                           input logic [10:0] exp_frame, input bit exp_done,
                           input bit exp_err, input bit chk_inh);
    logic [10:0] cap;
    bit ok;
    int bd, be;
    bd = done_cnt;
    be = err_cnt;
    send(d);
    device_frame(ack, 11, cap, ok);
    wait_result(bd, be);
    check({name, "_start"}, 32'(ok), 32'd1);
    check({name, "_frame"}, 32'(cap), 32'(exp_frame));
    check({name, "_done"}, 32'(done_cnt - bd), 32'(exp_done));
    check({name, "_err"}, 32'(err_cnt - be), 32'(exp_err));
    check({name, "_ready"}, 32'(tx_ready), 32'd1);
    check({name, "_oe_idle"}, 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
    if (chk_inh) check({name, "_inhibit_len"}, 32'(last_inh), 32'(INH));
  endtask

  initial begin
    logic [10:0] cap;
    bit ok;
    int bd, be, t;
    logic [7:0] rd;
    bit rack;

    vecs[0] = '{8'hED, 1'b1, 11'h7DA, 1'b1, 1'b0};
    vecs[1] = '{8'h01, 1'b1, 11'h402, 1'b1, 1'b0};
    vecs[2] = '{8'h00, 1'b1, 11'h600, 1'b1, 1'b0};
    vecs[3] = '{8'hF4, 1'b1, 11'h5E8, 1'b1, 1'b0};
    vecs[4] = '{8'hAA, 1'b0, 11'h754, 1'b0, 1'b1};
    vecs[5] = '{8'hFF, 1'b1, 11'h7FE, 1'b1, 1'b0};

    rst          = 1'b1;
    tx_valid     = 1'b0;
    tx_data      = 8'h00;
    dev_clk_rel  = 1'b1;
    dev_data_rel = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(tx_ready), 32'd1);
    check("rst_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
    check("rst_pulses", 32'({tx_done, tx_error}), 32'd0);

    // A request present in the first cycle after reset is accepted.
    tx_valid = 1'b1;
    tx_data  = 8'h00;
    rst      = 1'b0;
    @(negedge clk);
    tx_valid = 1'b0;
    check("first_cycle_accept_clk_oe", 32'(ps2_clk_oe), 32'd1);
    check("first_cycle_accept_ready", 32'(tx_ready), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 6; i++)
      run_frame($sformatf("vec%0d", i), vecs[i].data, vecs[i].ack, vecs[i].frame,
                vecs[i].done, vecs[i].err, 1'b1);

    for (int i = 0; i < 6; i++) begin
      rd   = 8'($urandom_range(0, 255));
      rack = ($urandom_range(0, 3) != 0);
      run_frame($sformatf("rnd%0d", i), rd, rack, model_frame(rd), rack, !rack, 1'b0);
    end

    // Requests while busy are ignored and the frame in flight is unchanged.
    bd = done_cnt;
    be = err_cnt;
    send(8'h3C);
    fork
      device_frame(1'b1, 11, cap, ok);
      begin
        repeat (10) @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = 8'hFF;
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (INH + 100) @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = 8'hFF;
        @(negedge clk);
        tx_valid = 1'b0;
      end
    join
    wait_result(bd, be);
    check("busy_frame", 32'(cap), 32'(model_frame(8'h3C)));
    check("busy_done", 32'(done_cnt - bd), 32'd1);
    check("busy_err", 32'(err_cnt - be), 32'd0);
    repeat (20) @(negedge clk);
    check("busy_no_new_frame", 32'(ps2_clk_oe), 32'd0);

    // Reset in the middle of the data bits abandons the frame silently.
    bd = done_cnt;
    be = err_cnt;
    send(8'h52);
    device_frame(1'b1, 4, cap, ok);
    repeat (5) @(negedge clk);
    check("pre_rst_data_oe", 32'(ps2_data_oe), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
    check("mid_rst_ready", 32'(tx_ready), 32'd1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_rst_done", 32'(done_cnt - bd), 32'd0);
    check("mid_rst_err", 32'(err_cnt - be), 32'd0);
    run_frame("after_rst_F4", 8'hF4, 1'b1, model_frame(8'hF4), 1'b1, 1'b0, 1'b1);

    // Device never clocks: error exactly TMO cycles after clock release.
    bd = done_cnt;
    be = err_cnt;
    send(8'h12);
    t = 0;
    while (err_cnt == be && t < INH + TMO + 200) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    check("tmo_err", 32'(err_cnt - be), 32'd1);
    check("tmo_latency", 32'(err_cyc - rel_cyc), 32'(TMO));
    check("tmo_oe", 32'(oe_at_err), 32'd0);
    check("tmo_done", 32'(done_cnt - bd), 32'd0);
    check("tmo_ready", 32'(tx_ready), 32'd1);

    check("no_done_err_overlap", 32'(both_seen), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_err);
    $fatal(1, "watchdog");
  end

endmodule
